// File: rtl/mb_add_seq_pkg.sv
// Shared types and constants for the multi-byte sequential adder.
package mb_add_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    // IDLE: beat counter at 0, the next beat starts a transaction.
    // BUSY: a transaction is partially accepted.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Width of the beat counter for a given bytes-per-operand count.
    function automatic int cnt_width(input int num_bytes);
        return $clog2(num_bytes);
    endfunction

endpackage

// File: rtl/mb_add_seq_if.sv
// Beat stream interface for mb_add_seq: operand beats in, result beats out.
//
// Handshake (both sides): a beat transfers on a rising clock edge where
// valid && ready are both high. A producer holding valid keeps its data
// stable until the transfer; ready may depend combinationally on the
// other side's ready (in_ready follows out_ready).
interface mb_add_seq_if;
    import mb_add_pkg::*;

    logic   in_valid;
    logic   in_ready;
    byte_t  in_a;
    byte_t  in_b;
    logic   in_cin;
    logic   out_valid;
    logic   out_ready;
    byte_t  out_sum;
    logic   out_last;
    logic   out_cout;
    logic   out_ovf;
    logic   busy;
    state_t state;   // debug view of the beat-sequencing FSM

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_last, out_cout, out_ovf,
               busy, state
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_last, out_cout, out_ovf,
               busy, state
    );
endinterface

// File: rtl/mb_add_seq_cla8_core.sv
// 8-bit carry-lookahead adder core, purely combinational.
module cla8_core
    import mb_add_pkg::*;
(
    input  byte_t a,
    input  byte_t b,
    input  logic  cin,
    output byte_t sum,
    output logic  cout
);
    byte_t             gen;
    byte_t             prop;
    logic [BYTE_W:0]   carry;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Each carry is expanded from generate/propagate terms directly, so no
    // carry depends on a lower-order carry signal.
    always_comb begin
        logic term;
        logic prod;
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < BYTE_W; i++) begin
            term = gen[i];
            prod = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                term = term | (prod & gen[j]);
                prod = prod & prop[j];
            end
            term         = term | (prod & cin);
            carry[i + 1] = term;
        end
    end

    assign sum  = prop ^ carry[BYTE_W-1:0];
    assign cout = carry[BYTE_W];
endmodule

// File: rtl/mb_add_seq.sv
// Multi-byte sequential adder: streams LSB-first byte pairs through one
// 8-bit CLA core, chaining the carry between beats of a transaction.
module mb_add_seq
    import mb_add_pkg::*;
#(
    parameter int NUM_BYTES = 4
) (
    input logic         clk,
    input logic         rst_n,
    mb_add_seq_if.slave bus
);
    localparam int               CNT_W     = cnt_width(NUM_BYTES);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BYTES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             out_valid_q, out_valid_d;
    byte_t            out_sum_q, out_sum_d;
    logic             out_last_q, out_last_d;
    logic             out_cout_q, out_cout_d;
    logic             out_ovf_q, out_ovf_d;

    logic             accept;
    logic             last_beat;
    logic             c_in;
    byte_t            core_sum;
    logic             core_cout;
    logic             byte_ovf;

    // No skid buffer: a new beat is taken only when the output register is
    // empty or being drained in the same cycle.
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    assign state     = (cnt_q == '0) ? ST_IDLE : ST_BUSY;
    assign last_beat = (cnt_q == LAST_BEAT);
    assign c_in      = (state == ST_IDLE) ? bus.in_cin : carry_q;

    cla8_core u_core (
        .a    (bus.in_a),
        .b    (bus.in_b),
        .cin  (c_in),
        .sum  (core_sum),
        .cout (core_cout)
    );

    // Sign bits of this byte only matter on the top byte.
    assign byte_ovf = (bus.in_a[7] == bus.in_b[7]) && (core_sum[7] != bus.in_a[7]);

    // Next-state and output-register logic; everything holds unless a beat
    // is accepted or the held result drains.
    always_comb begin
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_last_d  = out_last_q;
        out_cout_d  = out_cout_q;
        out_ovf_d   = out_ovf_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_sum_d   = core_sum;
            out_last_d  = last_beat;
            out_cout_d  = last_beat && core_cout;
            out_ovf_d   = last_beat && byte_ovf;

            case (state)
                ST_IDLE: begin
                    // At least two beats per transaction, so beat 0 is never last.
                    cnt_d   = CNT_W'(1);
                    carry_d = core_cout;
                end
                default: begin
                    if (last_beat) begin
                        cnt_d   = '0;
                        carry_d = 1'b0;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        carry_d = core_cout;
                    end
                end
            endcase
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_last_q  <= 1'b0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_last_q  <= out_last_d;
            out_cout_q  <= out_cout_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_cout  = out_cout_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.busy      = (state == ST_BUSY);
    assign bus.state     = state;
endmodule
